// File: rtl/adc_pipe_packer_if.sv
// Handshake bundle between the ADC sample FIFO, the packer and the Pipe Out endpoint.
// master = packer side, slave = FIFO/host side.
interface adc_pipe_packer_if #(
  parameter int PRECISION        = 10,
  parameter int FIFO_COUNT_WIDTH = 12,
  parameter int PIPE_WIDTH       = 16
);
  logic                        start;
  logic [FIFO_COUNT_WIDTH-1:0] frame_len;
  logic                        abort;
  logic [PRECISION-1:0]        fifo_dout;
  logic                        fifo_empty;
  logic                        fifo_rd_en;
  logic                        pipe_read;
  logic [PIPE_WIDTH-1:0]       pipe_data;
  logic                        pipe_valid;
  logic                        busy;
  logic                        done;
  logic                        underrun;

  modport master (
    input  start, frame_len, abort, fifo_dout, fifo_empty, pipe_read,
    output fifo_rd_en, pipe_data, pipe_valid, busy, done, underrun
  );

  modport slave (
    output start, frame_len, abort, fifo_dout, fifo_empty, pipe_read,
    input  fifo_rd_en, pipe_data, pipe_valid, busy, done, underrun
  );
endinterface

// File: rtl/adc_pipe_packer.sv
// Drains frame_len ADC codes from the sample FIFO and presents them as tagged
// {first, seq, code} Pipe Out words through a 2-entry buffer with back-pressure.
module adc_pipe_packer #(
  parameter int PRECISION        = 10,
  parameter int FIFO_COUNT_WIDTH = 12,
  parameter int PIPE_WIDTH       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  adc_pipe_packer_if.master bus
);
  localparam int SEQ_WIDTH = PIPE_WIDTH - 1 - PRECISION;
  localparam logic [FIFO_COUNT_WIDTH-1:0] CNT_ONE = FIFO_COUNT_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t                      r_state;
  logic [FIFO_COUNT_WIDTH-1:0] r_len;
  logic [FIFO_COUNT_WIDTH-1:0] r_fetched;
  logic [FIFO_COUNT_WIDTH-1:0] r_delivered;
  logic [FIFO_COUNT_WIDTH-1:0] r_wr_idx;
  logic                        r_vld_p1;
  logic                        r_head;
  logic [1:0]                  r_occ;
  logic                        r_underrun;
  logic [PIPE_WIDTH-1:0]       r_buf [2];

  logic w_accept, w_rd_en, w_push, w_pop, w_last, w_wr_ptr;

  function automatic logic [PIPE_WIDTH-1:0] pack_word(
    input logic [FIFO_COUNT_WIDTH-1:0] idx,
    input logic [PRECISION-1:0]        code
  );
    pack_word                            = '0;
    pack_word[PIPE_WIDTH-1]              = (idx == '0);
    pack_word[PIPE_WIDTH-2 -: SEQ_WIDTH] = idx[SEQ_WIDTH-1:0];
    pack_word[PRECISION-1:0]             = code;
  endfunction

  assign w_accept = (r_state == S_IDLE) && bus.start && !bus.abort && (bus.frame_len != '0);
  // Reserve a buffer slot for every in-flight read so a returning word always fits.
  assign w_rd_en  = (r_state == S_STREAM) && !bus.abort && !bus.fifo_empty &&
                    (r_fetched < r_len) && ((r_occ + {1'b0, r_vld_p1}) < 2'd2);
  assign w_push   = (r_state == S_STREAM) && r_vld_p1 && !bus.abort;
  assign w_pop    = (r_state == S_STREAM) && bus.pipe_read && (r_occ != 2'd0);
  assign w_last   = w_pop && (r_delivered == (r_len - CNT_ONE));
  assign w_wr_ptr = r_head ^ r_occ[0];

  // p0 -> p1: read strobe issued; FIFO data returns one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_fetched   <= '0;
      r_delivered <= '0;
      r_wr_idx    <= '0;
      r_vld_p1    <= 1'b0;
      r_head      <= 1'b0;
      r_occ       <= 2'd0;
      r_underrun  <= 1'b0;
    end else begin
      r_vld_p1 <= w_rd_en;
      if (bus.abort) begin
        r_state <= S_IDLE;
        r_occ   <= 2'd0;
        r_head  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_state     <= S_STREAM;
              r_len       <= bus.frame_len;
              r_fetched   <= '0;
              r_delivered <= '0;
              r_wr_idx    <= '0;
              r_underrun  <= 1'b0;
              r_occ       <= 2'd0;
              r_head      <= 1'b0;
            end
          end
          S_STREAM: begin
            if (w_rd_en) r_fetched <= r_fetched + CNT_ONE;
            if (w_push)  r_wr_idx  <= r_wr_idx + CNT_ONE;
            if (w_pop) begin
              r_head      <= ~r_head;
              r_delivered <= r_delivered + CNT_ONE;
            end
            r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
            if (bus.pipe_read && (r_occ == 2'd0)) r_underrun <= 1'b1;
            if (w_last) r_state <= S_DONE;
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // p1 -> p2: returned code tagged and written behind the current head
  always_ff @(posedge clk) begin
    if (w_push) r_buf[w_wr_ptr] <= pack_word(r_wr_idx, bus.fifo_dout);
  end

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.pipe_valid = (r_occ != 2'd0);
  assign bus.pipe_data  = (r_occ != 2'd0) ? r_buf[r_head] : '0;
  assign bus.busy       = (r_state == S_STREAM);
  assign bus.done       = (r_state == S_DONE);
  assign bus.underrun   = r_underrun;
endmodule

// File: tb/tb_adc_pipe_packer.sv
// Directed bench for adc_pipe_packer: FIFO model, pop monitor and hand-computed words.
module tb_adc_pipe_packer;
  localparam int PRECISION = 10;
  localparam int FCW       = 12;
  localparam int PW        = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adc_pipe_packer_if #(.PRECISION(PRECISION), .FIFO_COUNT_WIDTH(FCW), .PIPE_WIDTH(PW)) bus ();

  adc_pipe_packer #(.PRECISION(PRECISION), .FIFO_COUNT_WIDTH(FCW), .PIPE_WIDTH(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [PRECISION-1:0] code;
    logic [PW-1:0]        exp;
  } vec_t;

  int                   n_cmp = 0;
  int                   n_err = 0;
  logic [PRECISION-1:0] fifo_q[$];
  logic [PW-1:0]        got_q[$];
  logic [PW-1:0]        exp_q[$];
  int                   rd_cnt = 0;
  int                   rd_viol = 0;
  int                   done_cnt = 0;
  bit                   rnd_empty = 1'b0;
  int                   base_rd;
  int                   base_done;

  // FIFO model: data valid one cycle after the read strobe
  always @(posedge clk) begin
    if (bus.fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (bus.fifo_empty || fifo_q.size() == 0) rd_viol <= rd_viol + 1;
      else bus.fifo_dout <= fifo_q.pop_front();
    end
  end

  always @(negedge clk) begin
    bus.fifo_empty = (fifo_q.size() == 0) || (rnd_empty && ($urandom_range(0, 1) == 0));
  end

  always @(negedge clk) begin
    if (bus.busy && bus.pipe_valid && bus.pipe_read) got_q.push_back(bus.pipe_data);
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] exp_word(input int idx, input logic [PRECISION-1:0] code);
    logic [4:0] seq;
    seq = idx[4:0];
    return {(idx == 0) ? 1'b1 : 1'b0, seq, code};
  endfunction

  task automatic push_code(input int idx, input logic [PRECISION-1:0] code);
    fifo_q.push_back(code);
    exp_q.push_back(exp_word(idx, code));
  endtask

  task automatic new_test();
    got_q.delete();
    exp_q.delete();
    fifo_q.delete();
    bus.pipe_read = 1'b0;
    base_rd   = rd_cnt;
    base_done = done_cnt;
  endtask

  task automatic start_frame(input int len);
    bus.frame_len = FCW'(len);
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic wait_words(input string nm, input int n, input int max_cyc);
    int c = 0;
    while (got_q.size() < n && c < max_cyc) begin
      tick();
      c++;
    end
    check(nm, got_q.size(), n);
  endtask

  task automatic check_frame(input string nm);
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) check($sformatf("%s_word%0d", nm, i), got_q[i], exp_q[i]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t2[4];
    t2[0] = '{code: 10'h3FF, exp: 16'h83FF};
    t2[1] = '{code: 10'h001, exp: 16'h0401};
    t2[2] = '{code: 10'h155, exp: 16'h0955};
    t2[3] = '{code: 10'h2AA, exp: 16'h0EAA};

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.frame_len = '0;
    bus.abort     = 1'b0;
    bus.pipe_read = 1'b0;
    tick(3);
    check("rst_pipe_valid", bus.pipe_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_underrun", bus.underrun, 0);
    check("rst_rd_en", bus.fifo_rd_en, 0);
    check("rst_pipe_data", bus.pipe_data, 0);
    rst_n = 1'b1;
    tick(2);

    // reset mid-frame with both buffer entries full
    new_test();
    for (int i = 0; i < 5; i++) push_code(i, 10'(10'h100 + i));
    start_frame(5);
    tick(6);
    check("t1_buffered_valid", bus.pipe_valid, 1);
    check("t1_rd_before_reset", rd_cnt - base_rd, 2);
    rst_n = 1'b0;
    #1;
    check("t1_busy_async", bus.busy, 0);
    check("t1_valid_async", bus.pipe_valid, 0);
    check("t1_data_async", bus.pipe_data, 0);
    check("t1_rd_en_async", bus.fifo_rd_en, 0);
    tick();
    rst_n = 1'b1;
    tick(2);
    new_test();
    push_code(0, 10'h2C3);
    push_code(1, 10'h03C);
    bus.pipe_read = 1'b1;
    start_frame(2);
    wait_words("t1_restart_words", 2, 40);
    tick(4);
    check_frame("t1_restart");
    check("t1_restart_done", done_cnt - base_done, 1);

    // table-driven frame of four codes, host reading continuously
    new_test();
    for (int i = 0; i < 4; i++) fifo_q.push_back(t2[i].code);
    bus.pipe_read = 1'b1;
    start_frame(4);
    wait_words("t2_words", 4, 60);
    tick(4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) check($sformatf("t2_word%0d", i), got_q[i], t2[i].exp);
    end
    check("t2_rd_count", rd_cnt - base_rd, 4);
    check("t2_done_pulse", done_cnt - base_done, 1);
    check("t2_idle", bus.busy, 0);

    // frame_len of zero is ignored
    new_test();
    push_code(0, 10'h011);
    start_frame(0);
    check("t0_not_busy", bus.busy, 0);
    tick(3);
    check("t0_no_reads", rd_cnt - base_rd, 0);

    // host stalls: only two reads outstanding, head word held stable
    new_test();
    for (int i = 0; i < 8; i++) push_code(i, 10'(10'h0F0 + 3 * i));
    start_frame(8);
    tick(5);
    check("t3_head_early", bus.pipe_data, 16'h80F0);
    bus.frame_len = FCW'(3);
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
    check("t3_start_ignored", bus.busy, 1);
    tick(14);
    check("t3_rd_stalled", rd_cnt - base_rd, 2);
    check("t3_head_stable", bus.pipe_data, 16'h80F0);
    check("t3_valid_held", bus.pipe_valid, 1);
    bus.pipe_read = 1'b1;
    wait_words("t3_words", 8, 100);
    tick(4);
    check_frame("t3");
    check("t3_rd_count", rd_cnt - base_rd, 8);
    check("t3_done_pulse", done_cnt - base_done, 1);

    // random empty flag, sequence tag wraps after 32 words
    new_test();
    for (int i = 0; i < 40; i++) push_code(i, 10'(i * 37 + 5));
    rnd_empty     = 1'b1;
    bus.pipe_read = 1'b1;
    start_frame(40);
    wait_words("t4_words", 40, 3000);
    tick(4);
    rnd_empty = 1'b0;
    check_frame("t4");
    if (got_q.size() > 32) begin
      check("t4_word0_hand", got_q[0], 16'h8005);
      check("t4_word31_hand", got_q[31], 16'h7C80);
      check("t4_word32_hand", got_q[32], 16'h00A5);
    end
    check("t4_rd_while_empty", rd_viol, 0);
    check("t4_rd_count", rd_cnt - base_rd, 40);
    check("t4_done_pulse", done_cnt - base_done, 1);

    // abort after three pops with one word still buffered
    new_test();
    for (int i = 0; i < 10; i++) push_code(i, 10'(10'h200 + i));
    bus.pipe_read = 1'b1;
    start_frame(10);
    wait_words("t5_three_pops", 3, 60);
    bus.abort     = 1'b1;
    bus.pipe_read = 1'b0;
    tick();
    bus.abort = 1'b0;
    check("t5_idle", bus.busy, 0);
    check("t5_valid_flushed", bus.pipe_valid, 0);
    check("t5_rd_en_low", bus.fifo_rd_en, 0);
    tick(8);
    check("t5_no_done", done_cnt - base_done, 0);
    check("t5_fifo_left", fifo_q.size(), 6);
    check("t5_pop_count", got_q.size(), 3);
    check_frame("t5");
    bus.frame_len = FCW'(4);
    bus.start     = 1'b1;
    bus.abort     = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("t5_abort_beats_start", bus.busy, 0);
    check("t5_underrun_sticky", bus.underrun, 1);

    // host read on an empty buffer sets the sticky underrun flag
    new_test();
    for (int i = 0; i < 4; i++) push_code(i, 10'(10'h3C0 - 5 * i));
    start_frame(4);
    check("t6_underrun_cleared", bus.underrun, 0);
    check("t6_valid_empty", bus.pipe_valid, 0);
    bus.pipe_read = 1'b1;
    tick();
    bus.pipe_read = 1'b0;
    check("t6_underrun_set", bus.underrun, 1);
    check("t6_no_pop", got_q.size(), 0);
    tick(5);
    check("t6_underrun_holds", bus.underrun, 1);
    bus.pipe_read = 1'b1;
    wait_words("t6_words", 4, 60);
    tick(4);
    check_frame("t6");
    check("t6_underrun_after_frame", bus.underrun, 1);
    bus.pipe_read = 1'b0;
    new_test();
    push_code(0, 10'h0AB);
    start_frame(1);
    check("t6_underrun_new_start", bus.underrun, 0);
    tick(3);
    bus.pipe_read = 1'b1;
    wait_words("t6_single", 1, 20);
    tick(3);
    check_frame("t6_single");
    check("t6_single_done", done_cnt - base_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
